// File: rtl/axis_bram_reader.sv
// Reads N accumulator words from BRAM port B and streams each one, arithmetically
// right-shifted, out of an AXI-Stream master port with tlast on the final word.
module axis_bram_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 16
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_aresetn,
  input  logic                        RD_start,
  input  logic [15:0]                 RD_samples_count,
  input  logic [4:0]                  RD_shift,
  output logic                        RD_busy,
  output logic                        RD_done,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tlast,
  output logic [BRAM_ADDR_WIDTH-1:0]  BRAM_PORTB_addr,
  output logic                        BRAM_PORTB_clk,
  output logic [BRAM_DATA_WIDTH-1:0]  BRAM_PORTB_wrdata,
  input  logic [BRAM_DATA_WIDTH-1:0]  BRAM_PORTB_rddata,
  output logic                        BRAM_PORTB_rst,
  output logic                        BRAM_PORTB_we,
  output logic [1:0]                  dbg_state
);

  localparam int DEPTH = 4;
  localparam int MAXW  = (AXIS_TDATA_WIDTH > BRAM_DATA_WIDTH) ? AXIS_TDATA_WIDTH : BRAM_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [15:0]                  n_q;
  logic [4:0]                   shift_q;
  logic [15:0]                  idx_q;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_q;
  logic                         v1_q, v1_last_q;
  logic                         v2_q, v2_last_q;
  logic [AXIS_TDATA_WIDTH-1:0]  fifo_data [DEPTH];
  logic                         fifo_last [DEPTH];
  logic [1:0]                   wr_ptr, rd_ptr;
  logic [2:0]                   cnt;
  logic [2:0]                   credit_used;
  logic                         start_ok, issue, issue_last, push, pop;
  logic signed [BRAM_DATA_WIDTH-1:0] shifted;
  logic signed [MAXW-1:0]            widened;
  logic [AXIS_TDATA_WIDTH-1:0]       conv;

  assign BRAM_PORTB_clk    = SYS_aclk;
  assign BRAM_PORTB_rst    = ~SYS_aresetn;
  assign BRAM_PORTB_we     = 1'b0;
  assign BRAM_PORTB_wrdata = '0;
  assign BRAM_PORTB_addr   = addr_q;
  assign dbg_state         = state_q;

  // Stream handshake: a beat transfers on a rising edge where tvalid and tready are
  // both high; once tvalid rises, tdata/tlast hold until that transfer happens.
  assign M_AXIS_tvalid = (cnt != 3'd0);
  assign M_AXIS_tdata  = fifo_data[rd_ptr];
  assign M_AXIS_tlast  = M_AXIS_tvalid & fifo_last[rd_ptr];

  assign RD_busy = (state_q == S_READ) || (state_q == S_DRAIN);
  assign RD_done = (state_q == S_DONE);

  assign push = v2_q;
  assign pop  = M_AXIS_tvalid & M_AXIS_tready;

  // Reads in the address and data stages already own a buffer slot.
  assign credit_used = {2'b00, v1_q} + {2'b00, v2_q} + cnt;
  assign issue_last  = (idx_q == n_q - 16'd1);

  always_comb begin
    shifted = $signed(BRAM_PORTB_rddata) >>> shift_q;
    widened = MAXW'(shifted);
    conv    = widened[AXIS_TDATA_WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    issue    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (RD_start) begin
          start_ok = 1'b1;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        if (n_q == 16'd0) begin
          state_d = S_DONE;
        end else if (credit_used < 3'(DEPTH)) begin
          issue = 1'b1;
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_last[rd_ptr]) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      n_q       <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      v1_q      <= 1'b0;
      v1_last_q <= 1'b0;
      v2_q      <= 1'b0;
      v2_last_q <= 1'b0;
    end else begin
      if (start_ok) begin
        n_q     <= RD_samples_count;
        shift_q <= RD_shift;
        idx_q   <= '0;
      end else if (issue) begin
        idx_q <= idx_q + 16'd1;
      end
      if (issue) addr_q <= BRAM_ADDR_WIDTH'(idx_q);
      v1_q      <= issue;
      v1_last_q <= issue & issue_last;
      v2_q      <= v1_q;
      v2_last_q <= v1_last_q;
    end
  end

  // Output buffer: written one cycle after the address stage, when rddata is valid.
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= conv;
        fifo_last[wr_ptr] <= v2_last_q;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      cnt <= cnt + {2'b00, push} - {2'b00, pop};
    end
  end

endmodule

// File: tb/tb_axis_bram_reader.sv
// Directed bench for axis_bram_reader: behavioural BRAM, expected-beat queue and
// a monitor that scores every stream handshake and checks stall stability.
module tb_axis_bram_reader;

  logic        SYS_aclk;
  logic        SYS_aresetn;
  logic        RD_start;
  logic [15:0] RD_samples_count;
  logic [4:0]  RD_shift;
  logic        RD_busy;
  logic        RD_done;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic        M_AXIS_tlast;
  logic [15:0] BRAM_PORTB_addr;
  logic        BRAM_PORTB_clk;
  logic [31:0] BRAM_PORTB_wrdata;
  logic [31:0] BRAM_PORTB_rddata;
  logic        BRAM_PORTB_rst;
  logic        BRAM_PORTB_we;
  logic [1:0]  dbg_state;

  axis_bram_reader dut (
    .SYS_aclk          (SYS_aclk),
    .SYS_aresetn       (SYS_aresetn),
    .RD_start          (RD_start),
    .RD_samples_count  (RD_samples_count),
    .RD_shift          (RD_shift),
    .RD_busy           (RD_busy),
    .RD_done           (RD_done),
    .M_AXIS_tdata      (M_AXIS_tdata),
    .M_AXIS_tvalid     (M_AXIS_tvalid),
    .M_AXIS_tready     (M_AXIS_tready),
    .M_AXIS_tlast      (M_AXIS_tlast),
    .BRAM_PORTB_addr   (BRAM_PORTB_addr),
    .BRAM_PORTB_clk    (BRAM_PORTB_clk),
    .BRAM_PORTB_wrdata (BRAM_PORTB_wrdata),
    .BRAM_PORTB_rddata (BRAM_PORTB_rddata),
    .BRAM_PORTB_rst    (BRAM_PORTB_rst),
    .BRAM_PORTB_we     (BRAM_PORTB_we),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    SYS_aclk = 1'b0;
    forever #5 SYS_aclk = ~SYS_aclk;
  end

  int cyc = 0;
  always @(posedge SYS_aclk) cyc <= cyc + 1;

  // ---------------- BRAM model (one-cycle read latency) ----------------
  logic [31:0] mem [0:63];
  always @(posedge SYS_aclk) BRAM_PORTB_rddata <= mem[BRAM_PORTB_addr[5:0]];

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int last_cnt = 0;
  int first_hs_cyc = -1;
  int last_hs_cyc  = -1;
  logic rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [32:0] exp_beat;

  always begin
    @(negedge SYS_aclk);
    #2;
    if (!SYS_aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata},
            {1'b1, prev_last, prev_data});
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        hs_cnt++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (M_AXIS_tlast) last_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {M_AXIS_tlast, M_AXIS_tdata}, 33'h1_dead_beef);
        end else begin
          exp_beat = exp_q.pop_front();
          chk("beat", {M_AXIS_tlast, M_AXIS_tdata}, exp_beat);
        end
      end
      prev_stall = M_AXIS_tvalid && !M_AXIS_tready;
      prev_data  = M_AXIS_tdata;
      prev_last  = M_AXIS_tlast;
    end
  end

  always @(negedge SYS_aclk) if (rand_ready) M_AXIS_tready = 1'($urandom_range(0, 1));

  // ---------------- driver tasks ----------------
  task automatic start_rd(input logic [15:0] n, input logic [4:0] sh);
    @(negedge SYS_aclk);
    RD_samples_count = n;
    RD_shift         = sh;
    RD_start         = 1'b1;
    @(negedge SYS_aclk);
    RD_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int done_cyc);
    int found = 0;
    done_cyc = -1;
    for (int i = 0; i < max_cyc && found == 0; i++) begin
      @(negedge SYS_aclk);
      if (RD_done) begin
        found    = 1;
        done_cyc = cyc;
      end
    end
    chk("done_timeout", 64'(found), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  int base_hs, base_last, dc;

  initial begin
    SYS_aresetn      = 1'b0;
    RD_start         = 1'b0;
    RD_samples_count = '0;
    RD_shift         = '0;
    M_AXIS_tready    = 1'b1;
    for (int k = 0; k < 64; k++) mem[k] = 32'(4 * k);

    repeat (3) @(negedge SYS_aclk);
    chk("rst_outputs", {M_AXIS_tvalid, M_AXIS_tlast, RD_busy, RD_done, M_AXIS_tdata}, 64'd0);
    chk("rst_addr", 64'(BRAM_PORTB_addr), 64'd0);
    chk("rst_bram_ctl", {BRAM_PORTB_rst, BRAM_PORTB_we, BRAM_PORTB_wrdata}, {1'b1, 1'b0, 32'd0});
    SYS_aresetn = 1'b1;
    @(negedge SYS_aclk);
    chk("bram_rst_release", 64'(BRAM_PORTB_rst), 64'd0);

    // N=8, shift 2, mem[k]=4k -> beats k, tready high
    base_hs = hs_cnt; base_last = last_cnt; first_hs_cyc = -1;
    for (int k = 0; k < 8; k++) exp_q.push_back({k == 7, 32'(k)});
    start_rd(16'd8, 5'd2);
    chk("busy_after_start", {RD_busy, RD_done, M_AXIS_tvalid}, 3'b100);
    @(negedge SYS_aclk); chk("lat_edge1", 64'(M_AXIS_tvalid), 64'd0);
    @(negedge SYS_aclk); chk("lat_edge2", 64'(M_AXIS_tvalid), 64'd0);
    @(negedge SYS_aclk); chk("lat_edge3", 64'(M_AXIS_tvalid), 64'd1);
    wait_done(50, dc);
    chk("t1_beats", 64'(hs_cnt - base_hs), 64'd8);
    chk("t1_back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'd7);
    chk("t1_done_next", 64'(dc), 64'(last_hs_cyc + 1));
    chk("t1_tlast_cnt", 64'(last_cnt - base_last), 64'd1);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_busy_low", {RD_busy, M_AXIS_tvalid}, 2'b00);

    // same readout with random tready
    base_hs = hs_cnt;
    for (int k = 0; k < 8; k++) exp_q.push_back({k == 7, 32'(k)});
    rand_ready = 1'b1;
    start_rd(16'd8, 5'd2);
    wait_done(300, dc);
    rand_ready = 1'b0;
    M_AXIS_tready = 1'b1;
    chk("t2_beats", 64'(hs_cnt - base_hs), 64'd8);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // single negative word: 0xFFFFFFF0 >>> 4 = -1
    base_hs = hs_cnt; base_last = last_cnt;
    mem[0] = 32'hFFFF_FFF0;
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    start_rd(16'd1, 5'd4);
    wait_done(50, dc);
    chk("t3_beats", 64'(hs_cnt - base_hs), 64'd1);
    chk("t3_tlast_cnt", 64'(last_cnt - base_last), 64'd1);
    mem[0] = 32'd0;

    // N=0: straight to DONE, no beats
    base_hs = hs_cnt;
    start_rd(16'd0, 5'd0);
    chk("n0_cycle1", {RD_busy, RD_done, M_AXIS_tvalid}, 3'b100);
    @(negedge SYS_aclk);
    chk("n0_cycle2", {RD_busy, RD_done, M_AXIS_tvalid}, 3'b010);
    repeat (3) begin
      @(negedge SYS_aclk);
      chk("n0_idle", {RD_busy, M_AXIS_tvalid}, 2'b00);
    end
    chk("n0_beats", 64'(hs_cnt - base_hs), 64'd0);

    // N=16, async reset after beat 5, then N=4
    base_hs = hs_cnt;
    for (int k = 0; k < 16; k++) exp_q.push_back({k == 15, 32'(4 * k)});
    start_rd(16'd16, 5'd0);
    for (int i = 0; i < 60 && (hs_cnt - base_hs) < 6; i++) @(negedge SYS_aclk);
    #1 SYS_aresetn = 1'b0;
    #1;
    chk("midrst_stream", {M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata}, 64'd0);
    chk("midrst_status", {RD_busy, RD_done, BRAM_PORTB_addr}, 64'd0);
    chk("midrst_beats", 64'(hs_cnt - base_hs), 64'd6);
    exp_q.delete();
    repeat (2) @(negedge SYS_aclk);
    SYS_aresetn = 1'b1;
    base_hs = hs_cnt; base_last = last_cnt;
    for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, 32'(4 * k)});
    start_rd(16'd4, 5'd0);
    wait_done(50, dc);
    repeat (3) @(negedge SYS_aclk);
    chk("t5_beats", 64'(hs_cnt - base_hs), 64'd4);
    chk("t5_tlast_cnt", 64'(last_cnt - base_last), 64'd1);
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // RD_start pulsed mid-readout is ignored
    base_hs = hs_cnt; base_last = last_cnt;
    for (int k = 0; k < 8; k++) exp_q.push_back({k == 7, 32'(2 * k)});
    start_rd(16'd8, 5'd1);
    repeat (3) @(negedge SYS_aclk);
    RD_samples_count = 16'd3;
    RD_start = 1'b1;
    @(negedge SYS_aclk);
    RD_start = 1'b0;
    chk("t6_still_busy", 64'(RD_busy), 64'd1);
    wait_done(50, dc);
    repeat (4) @(negedge SYS_aclk);
    chk("t6_beats", 64'(hs_cnt - base_hs), 64'd8);
    chk("t6_tlast_cnt", 64'(last_cnt - base_last), 64'd1);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
